// File: rtl/video_src_mux.sv
// ---------------------------------------------------------------------------
// video_src_mux
//
// Selects one of NUM_SRC pixel streams and forwards it with one register
// stage. Source switches are requested with sel_req/sel_stb. A switch is
// held pending until the requested source starts a new frame. The switch
// then happens on that first pixel, so the new source's frame is never cut
// at the top. If that frame start does not arrive within TIMEOUT_CYC cycles,
// the request is abandoned.
//
// Optional feature (compile-time macro VSRC_TPG_EN):
//   Adds a free-running colour-bar test-pattern generator as source index
//   NUM_SRC. Without the macro that index is simply out of range.
//
// Ports:
//   clk        single clock for all logic
//   areset_n   asynchronous active-low reset
//   src_pix    NUM_SRC*PIX_W   source pixels, source i at [i*PIX_W +: PIX_W]
//   src_vld    NUM_SRC         per-source pixel valid
//   src_sof    NUM_SRC         first pixel of frame (qualified by src_vld)
//   src_eol    NUM_SRC         last pixel of line (qualified by src_vld)
//   sel_req    SEL_W           requested source index
//   sel_stb    1               one-cycle strobe qualifying sel_req
//   out_pix    PIX_W           forwarded pixel (holds when out_vld=0)
//   out_vld    1               forwarded valid
//   out_sof    1               forwarded start of frame
//   out_eol    1               forwarded end of line
//   cur_sel    SEL_W           index currently forwarded
//   sw_busy    1               a switch is pending
//   sw_done    1               pulse: switch completed / already selected
//   sw_err     1               pulse: request out of range or timed out
//   frame_cnt  16              number of out_sof emitted (wraps)
// ---------------------------------------------------------------------------
module video_src_mux #(
  parameter int NUM_SRC     = 2,
  parameter int PIX_W       = 24,
  parameter int TIMEOUT_CYC = 2**20,
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  localparam int SEL_W      = ($clog2(NUM_SRC + 1) < 1) ? 1 : $clog2(NUM_SRC + 1)
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic [NUM_SRC*PIX_W-1:0] src_pix,
  input  logic [NUM_SRC-1:0]       src_vld,
  input  logic [NUM_SRC-1:0]       src_sof,
  input  logic [NUM_SRC-1:0]       src_eol,
  input  logic [SEL_W-1:0]         sel_req,
  input  logic                     sel_stb,
  output logic [PIX_W-1:0]         out_pix,
  output logic                     out_vld,
  output logic                     out_sof,
  output logic                     out_eol,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     sw_busy,
  output logic                     sw_done,
  output logic                     sw_err,
  output logic [15:0]              frame_cnt
);

  // Input slots are padded to a power of two so any SEL_W-bit index is a
  // legal array access; unused slots read as an idle source.
  localparam int NSLOT = 2**SEL_W;
`ifdef VSRC_TPG_EN
  localparam int NUM_IN = NUM_SRC + 1;
`else
  localparam int NUM_IN = NUM_SRC;
`endif
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

  localparam int TO_W = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_SRC < 1 || NUM_SRC > 8) begin : g_bad_num_src
    $error("video_src_mux: NUM_SRC must be in 1..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("video_src_mux: TIMEOUT_CYC must be at least 1");
  end
  if (H_ACTIVE < 8 || (H_ACTIVE % 8) != 0 || H_BLANK < 0 || V_ACTIVE < 1) begin : g_bad_timing
    $error("video_src_mux: H_ACTIVE must be a positive multiple of 8, V_ACTIVE >= 1");
  end

  typedef enum logic {
    LOCKED  = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t               state, state_nx;
  logic [SEL_W-1:0]     target, target_nx, cur_sel_nx, fwd_sel;
  logic [TO_W-1:0]      to_cnt, to_cnt_nx;

  logic [PIX_W-1:0]     in_pix [NSLOT];
  logic [NSLOT-1:0]     in_vld, in_sof, in_eol;

  logic                 req_ok, stb_ok, stb_bad, tgt_sof;
  logic                 ev_same, ev_switch, ev_timeout;
  logic                 done_nx, err_nx, busy_nx;
  logic [PIX_W-1:0]     fwd_pix;
  logic                 fwd_vld, fwd_sof, fwd_eol;

`ifdef VSRC_TPG_EN
  // ------------------------------------------------------------------
  // Colour-bar test-pattern generator. Free-runs from reset: H_ACTIVE
  // pixels then H_BLANK idle cycles per line, V_ACTIVE lines per frame,
  // no vertical blanking. The bar index is tracked with a small
  // sub-counter instead of dividing h by H_ACTIVE/8.
  // ------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int BAR_LEN = H_ACTIVE / 8;
  localparam int H_W = ($clog2(H_TOTAL) < 1) ? 1 : $clog2(H_TOTAL);
  localparam int V_W = ($clog2(V_ACTIVE) < 1) ? 1 : $clog2(V_ACTIVE);
  localparam int B_W = ($clog2(BAR_LEN) < 1) ? 1 : $clog2(BAR_LEN);
  localparam logic [H_W-1:0] H_ACT_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [H_W-1:0] H_TOT_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_ACTIVE - 1);
  localparam logic [B_W-1:0] BAR_LAST   = B_W'(BAR_LEN - 1);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic [2:0]     bar_idx;
  logic [B_W-1:0] bar_pos;
  logic           tpg_act;
  logic [23:0]    tpg_rgb;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      bar_idx <= '0;
      bar_pos <= '0;
    end else begin
      if (h_cnt == H_TOT_LAST) begin
        h_cnt   <= '0;
        bar_idx <= '0;
        bar_pos <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
        if (tpg_act) begin
          if (bar_pos == BAR_LAST) begin
            bar_pos <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_pos <= bar_pos + B_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    tpg_act = (h_cnt <= H_ACT_LAST);
    case (bar_idx)
      3'd0:    tpg_rgb = 24'hFFFFFF;
      3'd1:    tpg_rgb = 24'hFFFF00;
      3'd2:    tpg_rgb = 24'h00FFFF;
      3'd3:    tpg_rgb = 24'h00FF00;
      3'd4:    tpg_rgb = 24'hFF00FF;
      3'd5:    tpg_rgb = 24'hFF0000;
      3'd6:    tpg_rgb = 24'h0000FF;
      default: tpg_rgb = 24'h000000;
    endcase
  end
`endif

  // Gather the external sources (and the TPG when present) into slots.
  always_comb begin
    in_vld = '0;
    in_sof = '0;
    in_eol = '0;
    for (int i = 0; i < NSLOT; i++) begin
      in_pix[i] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      in_pix[i] = src_pix[i*PIX_W +: PIX_W];
      in_vld[i] = src_vld[i];
      in_sof[i] = src_sof[i];
      in_eol[i] = src_eol[i];
    end
`ifdef VSRC_TPG_EN
    in_pix[NUM_SRC] = PIX_W'(tpg_rgb);
    in_vld[NUM_SRC] = tpg_act;
    in_sof[NUM_SRC] = tpg_act && (h_cnt == '0) && (v_cnt == '0);
    in_eol[NUM_SRC] = (h_cnt == H_ACT_LAST);
`endif
  end

  // State register: FSM state, pending target, selected source, timeout.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= LOCKED;
      target  <= '0;
      cur_sel <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nx;
      target  <= target_nx;
      cur_sel <= cur_sel_nx;
      to_cnt  <= to_cnt_nx;
    end
  end

  // Next-state logic. An out-of-range strobe only raises sw_err; it does
  // not disturb a pending switch. A valid strobe while pending wins over a
  // simultaneous frame start of the old target.
  always_comb begin
    state_nx   = state;
    target_nx  = target;
    cur_sel_nx = cur_sel;
    to_cnt_nx  = to_cnt;
    ev_same    = 1'b0;
    ev_switch  = 1'b0;
    ev_timeout = 1'b0;

    req_ok  = ({1'b0, sel_req} < NUM_IN_W);
    stb_ok  = sel_stb & req_ok;
    stb_bad = sel_stb & ~req_ok;
    tgt_sof = in_vld[target] & in_sof[target];

    case (state)
      LOCKED: begin
        if (stb_ok) begin
          if (sel_req == cur_sel) begin
            ev_same = 1'b1;
          end else begin
            target_nx = sel_req;
            to_cnt_nx = '0;
            state_nx  = PENDING;
          end
        end
      end
      PENDING: begin
        if (stb_ok) begin
          to_cnt_nx = '0;
          if (sel_req == cur_sel) begin
            ev_same  = 1'b1;
            state_nx = LOCKED;
          end else begin
            target_nx = sel_req;
          end
        end else if (tgt_sof) begin
          ev_switch  = 1'b1;
          cur_sel_nx = target;
          to_cnt_nx  = '0;
          state_nx   = LOCKED;
        end else if (to_cnt == TO_LAST) begin
          ev_timeout = 1'b1;
          to_cnt_nx  = '0;
          state_nx   = LOCKED;
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end
      default: state_nx = LOCKED;
    endcase
  end

  // Output decode. On the switching cycle the new target's first pixel is
  // forwarded, truncating whatever frame the old source was in.
  always_comb begin
    fwd_sel = ev_switch ? target : cur_sel;
    fwd_pix = in_pix[fwd_sel];
    fwd_vld = in_vld[fwd_sel];
    fwd_sof = in_vld[fwd_sel] & in_sof[fwd_sel];
    fwd_eol = in_vld[fwd_sel] & in_eol[fwd_sel];
    done_nx = ev_same | ev_switch;
    err_nx  = stb_bad | ev_timeout;
    busy_nx = (state_nx == PENDING);
  end

  // Registered outputs. out_pix keeps the last valid pixel during gaps.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      out_pix   <= '0;
      out_vld   <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      sw_busy   <= 1'b0;
      sw_done   <= 1'b0;
      sw_err    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      out_vld <= fwd_vld;
      out_sof <= fwd_sof;
      out_eol <= fwd_eol;
      if (fwd_vld) begin
        out_pix <= fwd_pix;
      end
      if (fwd_sof) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      sw_busy <= busy_nx;
      sw_done <= done_nx;
      sw_err  <= err_nx;
    end
  end

endmodule

// File: tb/tb_video_src_mux.sv
// ---------------------------------------------------------------------------
// tb_video_src_mux
//
// Scoreboard bench for video_src_mux. The stimulus side drives directed
// source patterns and pushes the pixel the mux should forward into a queue.
// A monitor pops and compares that queue on every cycle the DUT presents
// out_vld. Control outputs are checked directly after the relevant cycles.
// ---------------------------------------------------------------------------
module tb_video_src_mux;

  localparam int NUM_SRC     = 2;
  localparam int PIX_W       = 24;
  localparam int TIMEOUT_CYC = 16;
  localparam int H_ACTIVE    = 16;
  localparam int H_BLANK     = 4;
  localparam int V_ACTIVE    = 2;
  localparam int SEL_W       = 2;

  logic                     clk = 1'b0;
  logic                     areset_n;
  logic [NUM_SRC*PIX_W-1:0] src_pix;
  logic [NUM_SRC-1:0]       src_vld, src_sof, src_eol;
  logic [SEL_W-1:0]         sel_req;
  logic                     sel_stb;
  logic [PIX_W-1:0]         out_pix;
  logic                     out_vld, out_sof, out_eol;
  logic [SEL_W-1:0]         cur_sel;
  logic                     sw_busy, sw_done, sw_err;
  logic [15:0]              frame_cnt;

  typedef struct packed {
    logic [23:0] pix;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          seq = 0;
  int          exp_frames = 0;
  int          done_seen = 0;
  int          err_seen = 0;
  int          exp_done = 0;
  int          exp_err = 0;
  bit          tpg_mode = 1'b0;
  logic [23:0] last_pix = '0;

  video_src_mux #(
    .NUM_SRC     (NUM_SRC),
    .PIX_W       (PIX_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE)
  ) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .src_pix   (src_pix),
    .src_vld   (src_vld),
    .src_sof   (src_sof),
    .src_eol   (src_eol),
    .sel_req   (sel_req),
    .sel_stb   (sel_stb),
    .out_pix   (out_pix),
    .out_vld   (out_vld),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .cur_sel   (cur_sel),
    .sw_busy   (sw_busy),
    .sw_done   (sw_done),
    .sw_err    (sw_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Distinct, recognisable pixel per source and per cycle.
  function automatic logic [23:0] pix_of(input int s, input int k);
    return {8'(160 + s), 16'(k)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One cycle of stimulus. exp_src names the source whose pixel the mux
  // should forward this cycle (-1: nothing expected).
  task automatic applyStimulus(input logic [1:0] vld, input logic [1:0] sof,
                               input logic [1:0] eol, input bit stb,
                               input logic [SEL_W-1:0] req, input int exp_src);
    exp_t e;
    seq++;
    src_pix = {pix_of(1, seq), pix_of(0, seq)};
    src_vld = vld;
    src_sof = sof;
    src_eol = eol;
    sel_stb = stb;
    sel_req = req;
    if (exp_src >= 0 && vld[exp_src]) begin
      e.pix = pix_of(exp_src, seq);
      e.sof = sof[exp_src];
      e.eol = eol[exp_src];
      exp_q.push_back(e);
      last_pix = e.pix;
      if (e.sof) exp_frames++;
    end
    @(posedge clk);
    #1;
    sel_stb = 1'b0;
    src_vld = '0;
    src_sof = '0;
    src_eol = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, '0, -1);
  endtask

  // Monitor: compares forwarded pixels against the scoreboard and counts
  // control pulses.
  always @(negedge clk) begin
    if (areset_n) begin
      if (sw_done) done_seen++;
      if (sw_err) err_seen++;
      if (!tpg_mode) begin
        if (out_vld) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected out_vld", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("out_pix", 32'(out_pix), 32'(mon_e.pix));
            checkOutput("out_sof", 32'(out_sof), 32'(mon_e.sof));
            checkOutput("out_eol", 32'(out_eol), 32'(mon_e.eol));
          end
        end else begin
          checkOutput("idle sof/eol", 32'({out_sof, out_eol}), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    areset_n = 1'b0;
    src_pix  = '0;
    src_vld  = '0;
    src_sof  = '0;
    src_eol  = '0;
    sel_req  = '0;
    sel_stb  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst out_vld", 32'(out_vld), 32'd0);
    checkOutput("rst out_pix", 32'(out_pix), 32'd0);
    checkOutput("rst cur_sel", 32'(cur_sel), 32'd0);
    checkOutput("rst frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst flags", 32'({sw_busy, sw_done, sw_err}), 32'd0);
    areset_n = 1'b1;
    idle(2);

    // 4x4 frame on source 0; source 1 also active (incl. sof) but ignored
    for (int ln = 0; ln < 4; ln++) begin
      for (int c = 0; c < 4; c++) begin
        applyStimulus(2'b11, (ln == 0 && c == 0) ? 2'b11 : 2'b00,
                      (c == 3) ? 2'b11 : 2'b00, 1'b0, '0, 0);
      end
      idle(1);
    end
    checkOutput("frame_cnt after frame", 32'(frame_cnt), 32'(exp_frames));
    checkOutput("cur_sel after frame", 32'(cur_sel), 32'd0);
    checkOutput("out_pix hold", 32'(out_pix), 32'(last_pix));

    // Request for the already-selected source
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, 2'd0, -1);
    exp_done++;
    checkOutput("same-sel sw_done", 32'(sw_done), 32'd1);
    checkOutput("same-sel sw_busy", 32'(sw_busy), 32'd0);
    idle(1);
    checkOutput("sw_done one cycle", 32'(sw_done), 32'd0);

    // Timeout: request source 1, which stays silent
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b1, 2'd1, 0);
    checkOutput("timeout busy rise", 32'(sw_busy), 32'd1);
    for (int n = 1; n <= 16; n++) begin
      applyStimulus(2'b01, 2'b00, (n % 4 == 3) ? 2'b01 : 2'b00, 1'b0, '0, 0);
      if (n == 15) begin
        checkOutput("no sw_err before cycle 16", 32'(sw_err), 32'd0);
        checkOutput("busy before timeout", 32'(sw_busy), 32'd1);
      end
    end
    exp_err++;
    checkOutput("timeout sw_err", 32'(sw_err), 32'd1);
    checkOutput("timeout busy fall", 32'(sw_busy), 32'd0);
    checkOutput("timeout cur_sel", 32'(cur_sel), 32'd0);
    idle(1);

    // Switch to source 1 mid-stream; its sof arrives 10 cycles later
    applyStimulus(2'b11, 2'b01, 2'b00, 1'b1, 2'd1, 0);
    for (int n = 1; n <= 9; n++) applyStimulus(2'b11, 2'b00, 2'b00, 1'b0, '0, 0);
    checkOutput("pending busy", 32'(sw_busy), 32'd1);
    checkOutput("pending cur_sel", 32'(cur_sel), 32'd0);
    applyStimulus(2'b11, 2'b10, 2'b00, 1'b0, '0, 1);
    exp_done++;
    checkOutput("switch cur_sel", 32'(cur_sel), 32'd1);
    checkOutput("switch sw_done", 32'(sw_done), 32'd1);
    checkOutput("switch busy", 32'(sw_busy), 32'd0);
    checkOutput("switch frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    for (int n = 0; n < 4; n++) applyStimulus(2'b11, 2'b00, (n == 3) ? 2'b11 : 2'b00, 1'b0, '0, 1);

    // Strobe back to cur_sel in the same cycle as target sof: no switch
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 2'd0, 1);
    checkOutput("retarget busy", 32'(sw_busy), 32'd1);
    applyStimulus(2'b11, 2'b01, 2'b00, 1'b1, 2'd1, 1);
    exp_done++;
    checkOutput("priority cur_sel", 32'(cur_sel), 32'd1);
    checkOutput("priority sw_done", 32'(sw_done), 32'd1);
    checkOutput("priority busy", 32'(sw_busy), 32'd0);
    idle(1);

    // Out-of-range requests
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, 2'd3, -1);
    exp_err++;
    checkOutput("oor sw_err", 32'(sw_err), 32'd1);
    checkOutput("oor cur_sel", 32'(cur_sel), 32'd1);
    checkOutput("oor busy", 32'(sw_busy), 32'd0);
`ifndef VSRC_TPG_EN
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, 2'd2, -1);
    exp_err++;
    checkOutput("no-tpg idx sw_err", 32'(sw_err), 32'd1);
    checkOutput("no-tpg idx cur_sel", 32'(cur_sel), 32'd1);
`endif

    // Out-of-range request while pending keeps the pending target
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 2'd0, 1);
    applyStimulus(2'b10, 2'b00, 2'b00, 1'b1, 2'd3, 1);
    exp_err++;
    checkOutput("pending oor sw_err", 32'(sw_err), 32'd1);
    checkOutput("pending oor busy", 32'(sw_busy), 32'd1);
    applyStimulus(2'b11, 2'b01, 2'b00, 1'b0, '0, 0);
    exp_done++;
    checkOutput("kept target cur_sel", 32'(cur_sel), 32'd0);
    checkOutput("kept target sw_done", 32'(sw_done), 32'd1);
    applyStimulus(2'b01, 2'b00, 2'b01, 1'b0, '0, 0);

    // Reset while pending
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b1, 2'd1, 0);
    applyStimulus(2'b01, 2'b00, 2'b00, 1'b0, '0, 0);
    @(negedge clk);
    #1;
    areset_n = 1'b0;
    #1;
    exp_frames = 0;
    checkOutput("async rst out_vld", 32'(out_vld), 32'd0);
    checkOutput("async rst out_pix", 32'(out_pix), 32'd0);
    checkOutput("async rst busy", 32'(sw_busy), 32'd0);
    checkOutput("async rst frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1;
    areset_n = 1'b1;
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b0, '0, 0);
    for (int n = 0; n < 3; n++) applyStimulus(2'b11, 2'b00, (n == 2) ? 2'b11 : 2'b00, 1'b0, '0, 0);
    checkOutput("post-rst cur_sel", 32'(cur_sel), 32'd0);
    checkOutput("post-rst busy", 32'(sw_busy), 32'd0);
    checkOutput("post-rst frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    idle(2);

    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    checkOutput("sw_done pulses", 32'(done_seen), 32'(exp_done));
    checkOutput("sw_err pulses", 32'(err_seen), 32'(exp_err));

`ifdef VSRC_TPG_EN
    // Switch to the test-pattern generator (index NUM_SRC) and check bars.
    begin
      bit found;
      int waited;
      found  = 1'b0;
      waited = 0;
      tpg_mode = 1'b1;
      while (!found && waited < 200) begin
        @(negedge clk);
        sel_stb = 1'b0;
        if (out_vld && out_sof && cur_sel == 2'd2) begin
          found = 1'b1;
        end else begin
          sel_req = 2'd2;
          sel_stb = (waited % 7 == 0);
          waited++;
        end
      end
      sel_stb = 1'b0;
      checkOutput("tpg switch", 32'(found), 32'd1);
      if (found) begin
        checkOutput("tpg h0 pix", 32'(out_pix), 32'hFFFFFF);
        for (int h = 1; h <= H_ACTIVE + H_BLANK; h++) begin
          @(negedge clk);
          if (h == H_ACTIVE / 8) checkOutput("tpg bar1 pix", 32'(out_pix), 32'hFFFF00);
          if (h == H_ACTIVE - 1) begin
            checkOutput("tpg last pix", 32'(out_pix), 32'h000000);
            checkOutput("tpg eol", 32'(out_eol), 32'd1);
          end
          if (h < H_ACTIVE) checkOutput("tpg active vld", 32'(out_vld), 32'd1);
          else if (h < H_ACTIVE + H_BLANK) checkOutput("tpg blank vld", 32'(out_vld), 32'd0);
          else begin
            checkOutput("tpg line1 vld", 32'({out_vld, out_sof}), 32'd2);
            checkOutput("tpg line1 pix", 32'(out_pix), 32'hFFFFFF);
          end
        end
      end
      tpg_mode = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_src_mux.md
VIDEO_SRC_MUX -- requirements
Module: video_src_mux

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of camera/ISP pixel sources (1..8).
REQ-002 SHALL have parameter PIX_W, default 24: pixel width, {R,G,B} 8:8:8 when 24.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2**20: maximum cycles to wait for the requested source's frame start.
REQ-004 SHALL have parameters H_ACTIVE=640, H_BLANK=160, V_ACTIVE=480: test-pattern timing; H_ACTIVE is a multiple of 8.
REQ-005 SHALL derive SEL_W = $clog2(NUM_SRC+1), minimum 1.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 areset_n  in  1  asynchronous, active-low reset.
REQ-008 src_pix  in  NUM_SRC*PIX_W  source pixels; source i in slice [i*PIX_W +: PIX_W].
REQ-009 src_vld  in  NUM_SRC  per-source pixel valid.
REQ-010 src_sof  in  NUM_SRC  first pixel of frame; meaningful only with src_vld.
REQ-011 src_eol  in  NUM_SRC  last pixel of line; meaningful only with src_vld.
REQ-012 sel_req  in  SEL_W  requested source index.
REQ-013 sel_stb  in  1  one-cycle strobe qualifying sel_req.
REQ-014 out_pix / out_vld / out_sof / out_eol  out  PIX_W/1/1/1  selected stream.
REQ-015 cur_sel  out  SEL_W  index currently forwarded.
REQ-016 sw_busy  out  1  high while a switch is pending.
REQ-017 sw_done / sw_err  out  1/1  one-cycle pulses: switch completed / request rejected or timed out.
REQ-018 frame_cnt  out  16  count of out_sof emitted.

Function
REQ-019 SHALL register all outputs; forwarded stream latency is exactly 1 cycle from source inputs.
REQ-020 SHALL implement FSM states LOCKED and PENDING; reset enters LOCKED.
REQ-021 LOCKED: forward source cur_sel (pix, vld, sof, eol); other sources ignored, with no backpressure.
REQ-022 LOCKED + sel_stb with valid sel_req != cur_sel: latch target, clear timeout counter, go PENDING.
REQ-023 LOCKED + sel_stb with sel_req == cur_sel: pulse sw_done next cycle, stay LOCKED.
REQ-024 Any sel_stb with sel_req out of range: pulse sw_err next cycle; state, target and cur_sel unchanged.
REQ-025 PENDING: keep forwarding old cur_sel; sw_busy=1; timeout counter increments every cycle.
REQ-026 PENDING + target src_vld&src_sof: in that same cycle cur_sel<=target, forward that pixel (out_sof=1 next cycle), pulse sw_done, go LOCKED; the old frame is truncated.
REQ-027 PENDING + valid sel_stb: retarget to new sel_req and restart the timeout; this takes priority over a simultaneous target sof; sel_req == cur_sel returns to LOCKED with sw_done.
REQ-028 PENDING + counter reaching TIMEOUT_CYC-1: go LOCKED on old cur_sel, pulse sw_err.
REQ-029 frame_cnt SHALL increment on every cycle with out_vld&out_sof; wraps 0xFFFF->0x0000.
REQ-030 out_pix SHALL hold its last value when out_vld=0; out_sof and out_eol SHALL be 0 when out_vld=0.

Reset
REQ-031 areset_n low SHALL asynchronously force: LOCKED, cur_sel=0, out_pix=0, out_vld/sof/eol=0, sw_busy=0, sw_done=0, sw_err=0, frame_cnt=0, timeout and TPG counters=0.
REQ-032 Reset during PENDING SHALL discard the target; after release the block forwards source 0.

Configuration
REQ-033 Macro VSRC_TPG_EN SHALL compile in a colour-bar test-pattern generator as source index NUM_SRC.
REQ-034 With VSRC_TPG_EN: TPG free-runs from reset; one pixel per cycle for H_ACTIVE cycles, then H_BLANK idle cycles, for V_ACTIVE lines with no vertical blank; sof at h=0,v=0; eol at h=H_ACTIVE-1.
REQ-035 With VSRC_TPG_EN: bar = h/(H_ACTIVE/8), colours white, yellow, cyan, green, magenta, red, blue, black (FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000); switching to the TPG follows REQ-026.
REQ-036 Without VSRC_TPG_EN: no TPG logic; index NUM_SRC is out of range per REQ-024.

Verification
REQ-037 Reset release, src 0 streams 4x4 frame -> out equals src 0 delayed 1 cycle, frame_cnt=1, cur_sel=0.
REQ-038 sel_req=1 strobed mid-frame, src 1 sof 10 cycles later -> src 0 forwarded 10 cycles, then src 1 with out_sof, sw_done once, cur_sel=1.
REQ-039 TIMEOUT_CYC=16, sel_req=1, src 1 silent -> sw_err on cycle 16, cur_sel stays 0, sw_busy falls.
REQ-040 sel_stb same cycle as target sof in PENDING, plus sel_req=NUM_SRC+1 -> retarget with no switch; out-of-range request gives sw_err and no state change.
REQ-041 VSRC_TPG_EN, NUM_SRC=2, sel_req=2 -> after TPG sof, pixel h=0 is FFFFFF, h=80 is FFFF00, h=639 is 000000 with out_eol, then 160 idle cycles.
REQ-042 areset_n pulsed low in PENDING -> outputs at reset values immediately; source 0 forwarded after release.
